vending_machine_param: RTL and testbench
========================================

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 The block SHALL have parameter PRICE, default 4, meaning the product price in half-yuan units (range 1 to 2^CREDIT_W-3).
REQ-002 The block SHALL have parameter CREDIT_W, default 4, meaning the width of the credit and change registers.
REQ-003 The block SHALL have parameter CHANGE_EN, default 1, meaning 1 = return overpayment as change, 0 = discard overpayment.
REQ-004 The block SHALL have port sys_clk, input, 1 bit, the clock; all logic is rising-edge.
REQ-005 The block SHALL have port sysRstN, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port piHalf, input, 1 bit, a 0.5-yuan coin strobe, sampled once per cycle.
REQ-007 The block SHALL have port piOne, input, 1 bit, a 1-yuan coin strobe, sampled once per cycle.
REQ-008 The block SHALL have port piCancel, input, 1 bit, a refund request.
REQ-009 The block SHALL have port OCola, output, 1 bit, a one-cycle vend pulse.
REQ-010 The block SHALL have port OChange, output, 1 bit, a one-cycle pulse per half-yuan returned.
REQ-011 The block SHALL have port OCoinRej, output, 1 bit, a one-cycle pulse when a coin is not accepted.
REQ-012 The block SHALL have port OBusy, output, 1 bit, high while change is being dispensed.
REQ-013 The block SHALL have port OCredit, output, CREDIT_W bits, the current accepted credit in half-yuan units.

Function
REQ-014 The FSM SHALL have states ACCUM and RETURN only; all outputs SHALL be registered.
REQ-015 In ACCUM, the coin value SHALL be add = piHalf*1 + piOne*2, so both coins in one cycle give add = 3, and both are accepted.
REQ-016 In ACCUM with piCancel=0, if credit+add >= PRICE, the block SHALL pulse OCola in the next cycle and set the change count to credit+add-PRICE.
REQ-017 On a vend, if CHANGE_EN=1 and the change count is nonzero, the FSM SHALL go to RETURN; otherwise credit SHALL become 0 and the FSM SHALL stay in ACCUM.
REQ-018 In ACCUM with piCancel=0 and credit+add < PRICE, credit SHALL be set to credit+add.
REQ-019 In ACCUM with piCancel=1, the block SHALL NOT vend; any same-cycle coins SHALL be added, and the full sum SHALL become the change count.
REQ-020 For a cancel, if the sum is nonzero the FSM SHALL go to RETURN, otherwise it SHALL stay in ACCUM; this applies regardless of CHANGE_EN.
REQ-021 In RETURN, OChange SHALL pulse high in consecutive cycles, one per unit, with the count decremented each cycle.
REQ-022 The RETURN state SHALL exit to ACCUM, with credit 0, in the cycle after the last pulse.
REQ-023 OBusy SHALL be high for every cycle the FSM is in RETURN.
REQ-024 The first OChange pulse SHALL occur in the same cycle as OCola, i.e. one cycle after the final coin; N units of change take N cycles.
REQ-025 In RETURN, coins SHALL NOT be accepted: each cycle with piHalf or piOne high SHALL give one OCoinRej pulse in the next cycle, and credit SHALL be unchanged.
REQ-026 In RETURN, piCancel SHALL be ignored.
REQ-027 OCredit SHALL show the registered credit; it SHALL read 0 during RETURN.
REQ-028 Credit arithmetic SHALL be done at width CREDIT_W+1 so it cannot overflow; the maximum credit+add is PRICE+2.
REQ-029 An illegal state encoding SHALL recover to ACCUM with credit 0 and the change count 0.

Reset
REQ-030 While sysRstN=0, the state SHALL be ACCUM, credit and the change count SHALL be 0, and OCola, OChange, OCoinRej and OBusy SHALL be 0.
REQ-031 A reset asserted mid-RETURN SHALL abandon the remaining change, with no further OChange pulses.
REQ-032 The first coin SHALL be sampled on the first rising edge after sysRstN deasserts.

Structure
REQ-033 A shared package vm_pkg SHALL hold the state enum (ACCUM, RETURN), the coin-value constants HALF_UNITS=1 and ONE_UNITS=2, and a CREDIT_W legality check function.
REQ-034 The change counter and pulse generator SHALL be one sub-module, vm_change_ctr, taking a load strobe and a count in, and giving OChange and done out.
REQ-035 The FSM, credit register and coin decode SHALL live in the top level.

Verification
REQ-036 Defaults, inputs One, One -> OCola=1 in the cycle after the 2nd coin; no OChange; OCredit=0.
REQ-037 Defaults, inputs Half, Half, Half, then One -> OCola pulse; OChange pulses 1 cycle; OBusy high 1 cycle.
REQ-038 Defaults, inputs Half and One together (add=3), then piCancel -> 3 OChange pulses; no OCola.
REQ-039 Defaults, during RETURN drive piOne for 2 cycles -> 2 OCoinRej pulses; the change count and OCredit are unaffected.
REQ-040 CHANGE_EN=0, inputs One, Half, One -> OCola; no OChange; credit 0.
REQ-041 Assert sysRstN=0 after the 1st of 3 change pulses -> no further OChange; all outputs 0; a new One, One then vends normally.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the parameterised vending machine: state encoding,
// coin values and a parameter legality check.
package vm_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'b01,
        RETURN = 2'b10
    } vm_state_e;

    localparam int HALF_UNITS = 1;
    localparam int ONE_UNITS  = 2;

    // The credit register must hold PRICE+2 (largest credit+add) without wrapping.
    function automatic bit credit_w_ok(int credit_w, int price);
        return (credit_w >= 2) && (credit_w < 31) &&
               (price >= 1) && (price <= (1 << credit_w) - 3);
    endfunction

endpackage

// File: rtl/vm_change_ctr.sv
// Change counter: loads a unit count and emits one registered pulse per unit,
// the first pulse in the cycle right after the load.
module vm_change_ctr #(
    parameter int CREDIT_W = 4
) (
    input  logic                sys_clk,
    input  logic                sysRstN,
    input  logic                load,
    input  logic                clr,
    input  logic [CREDIT_W-1:0] count,
    output logic                change,
    output logic                done
);

    logic [CREDIT_W-1:0] cnt;

    // cnt holds the pulses still owed after the one currently on the output.
    always_ff @(posedge sys_clk or negedge sysRstN) begin
        if (!sysRstN) begin
            cnt    <= '0;
            change <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            change <= 1'b0;
        end else if (load && (count != '0)) begin
            cnt    <= count - CREDIT_W'(1);
            change <= 1'b1;
        end else if (cnt != '0) begin
            cnt    <= cnt - CREDIT_W'(1);
            change <= 1'b1;
        end else begin
            change <= 1'b0;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vending_machine_param.sv
// Parameterised vending machine: coin decode, credit register and ACCUM/RETURN
// FSM; change dispensing is delegated to vm_change_ctr.
module vending_machine_param
    import vm_pkg::*;
#(
    parameter int PRICE     = 4,
    parameter int CREDIT_W  = 4,
    parameter int CHANGE_EN = 1
) (
    input  logic                sys_clk,
    input  logic                sysRstN,
    input  logic                piHalf,
    input  logic                piOne,
    input  logic                piCancel,
    output logic                OCola,
    output logic                OChange,
    output logic                OCoinRej,
    output logic                OBusy,
    output logic [CREDIT_W-1:0] OCredit
);

    if (!credit_w_ok(CREDIT_W, PRICE)) begin : g_bad_params
        $error("vending_machine_param: PRICE must lie in 1..2**CREDIT_W-3");
    end

    localparam logic [1:0] S_ACCUM  = ACCUM;
    localparam logic [1:0] S_RETURN = RETURN;

    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] HALF_X  = (CREDIT_W+1)'(HALF_UNITS);
    localparam logic [CREDIT_W:0] ONE_X   = (CREDIT_W+1)'(ONE_UNITS);

    logic [1:0]          state, state_d;
    logic [CREDIT_W-1:0] credit, credit_d;
    logic [CREDIT_W:0]   add, sum, over;
    logic                cola_d, rej_d;
    logic                load, clr, done;
    logic [CREDIT_W-1:0] load_cnt;

    always_comb begin
        add      = (piHalf ? HALF_X : '0) + (piOne ? ONE_X : '0);
        sum      = {1'b0, credit} + add;
        over     = sum - PRICE_X;
        state_d  = state;
        credit_d = credit;
        cola_d   = 1'b0;
        rej_d    = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
        load_cnt = '0;
        case (state)
            S_ACCUM: begin
                if (piCancel) begin
                    // Refund is always dispensed, whatever CHANGE_EN says.
                    credit_d = '0;
                    if (sum != '0) begin
                        load     = 1'b1;
                        load_cnt = sum[CREDIT_W-1:0];
                        state_d  = S_RETURN;
                    end
                end else if (sum >= PRICE_X) begin
                    cola_d   = 1'b1;
                    credit_d = '0;
                    if ((CHANGE_EN != 0) && (over != '0)) begin
                        load     = 1'b1;
                        load_cnt = over[CREDIT_W-1:0];
                        state_d  = S_RETURN;
                    end
                end else begin
                    credit_d = sum[CREDIT_W-1:0];
                end
            end
            S_RETURN: begin
                rej_d = piHalf | piOne;
                if (done) begin
                    state_d = S_ACCUM;
                end
            end
            default: begin
                state_d  = S_ACCUM;
                credit_d = '0;
                clr      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sysRstN) begin
        if (!sysRstN) begin
            state    <= S_ACCUM;
            credit   <= '0;
            OCola    <= 1'b0;
            OCoinRej <= 1'b0;
            OBusy    <= 1'b0;
        end else begin
            state    <= state_d;
            credit   <= credit_d;
            OCola    <= cola_d;
            OCoinRej <= rej_d;
            OBusy    <= (state_d == S_RETURN);
        end
    end

    assign OCredit = credit;

    vm_change_ctr #(
        .CREDIT_W(CREDIT_W)
    ) u_change_ctr (
        .sys_clk (sys_clk),
        .sysRstN (sysRstN),
        .load    (load),
        .clr     (clr),
        .count   (load_cnt),
        .change  (OChange),
        .done    (done)
    );

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench: a default instance and a CHANGE_EN=0 instance share the
// same stimulus; a behavioural model queues expected outputs per cycle.
module tb_vending_machine_param;

    localparam int PRICE = 4;
    localparam int CW    = 4;

    typedef struct {
        logic cola;
        logic chg;
        logic rej;
        logic busy;
        int   credit;
    } exp_t;

    logic          sys_clk  = 1'b0;
    logic          sysRstN  = 1'b0;
    logic          piHalf   = 1'b0;
    logic          piOne    = 1'b0;
    logic          piCancel = 1'b0;
    logic          cola [2];
    logic          chg  [2];
    logic          rej  [2];
    logic          busy [2];
    logic [CW-1:0] credit [2];

    exp_t q0[$];
    exp_t q1[$];
    bit   m_ret    [2];
    int   m_credit [2];
    int   m_left   [2];
    int   n_chk  = 0;
    int   n_pass = 0;

    vending_machine_param #(.PRICE(PRICE), .CREDIT_W(CW), .CHANGE_EN(1)) dut (
        .sys_clk(sys_clk), .sysRstN(sysRstN), .piHalf(piHalf), .piOne(piOne),
        .piCancel(piCancel), .OCola(cola[0]), .OChange(chg[0]), .OCoinRej(rej[0]),
        .OBusy(busy[0]), .OCredit(credit[0]));

    vending_machine_param #(.PRICE(PRICE), .CREDIT_W(CW), .CHANGE_EN(0)) dut_nc (
        .sys_clk(sys_clk), .sysRstN(sysRstN), .piHalf(piHalf), .piOne(piOne),
        .piCancel(piCancel), .OCola(cola[1]), .OChange(chg[1]), .OCoinRej(rej[1]),
        .OBusy(busy[1]), .OCredit(credit[1]));

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected outputs for the cycle after these inputs are sampled.
    function automatic exp_t model_step(int k, bit h, bit o, bit c);
        exp_t e;
        int   sum;
        e = '{cola: 1'b0, chg: 1'b0, rej: 1'b0, busy: 1'b0, credit: 0};
        if (!m_ret[k]) begin
            sum = m_credit[k] + int'(h) + 2 * int'(o);
            if (c) begin
                m_credit[k] = 0;
                if (sum > 0) begin
                    m_ret[k] = 1; m_left[k] = sum - 1; e.chg = 1'b1;
                end
            end else if (sum >= PRICE) begin
                e.cola = 1'b1;
                m_credit[k] = 0;
                if (k == 0 && sum > PRICE) begin
                    m_ret[k] = 1; m_left[k] = sum - PRICE - 1; e.chg = 1'b1;
                end
            end else begin
                m_credit[k] = sum;
            end
        end else begin
            e.rej = h | o;
            if (m_left[k] > 0) begin
                e.chg = 1'b1; m_left[k]--;
            end else begin
                m_ret[k] = 0;
            end
        end
        e.busy   = m_ret[k];
        e.credit = m_credit[k];
        return e;
    endfunction

    task automatic compare(input int k, input exp_t e);
        chk($sformatf("cola%0d", k),   int'(cola[k]),   int'(e.cola));
        chk($sformatf("change%0d", k), int'(chg[k]),    int'(e.chg));
        chk($sformatf("coinrej%0d", k), int'(rej[k]),   int'(e.rej));
        chk($sformatf("busy%0d", k),   int'(busy[k]),   int'(e.busy));
        chk($sformatf("credit%0d", k), int'(credit[k]), e.credit);
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            compare(k, '{cola: 1'b0, chg: 1'b0, rej: 1'b0, busy: 1'b0, credit: 0});
        end
        chk({tag, "_qempty"}, q0.size() + q1.size(), 0);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit h, input bit o, input bit c);
        piHalf = h; piOne = o; piCancel = c;
        q0.push_back(model_step(0, h, o, c));
        q1.push_back(model_step(1, h, o, c));
        @(posedge sys_clk);
        #1;
        if (q0.size() == 0 || q1.size() == 0) chk("sb_underflow", 1, 0);
        else begin
            compare(0, q0.pop_front());
            compare(1, q1.pop_front());
        end
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ret[k] = 0; m_credit[k] = 0; m_left[k] = 0;
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_idle_outputs("reset");
        @(negedge sys_clk);
        sysRstN = 1'b1;

        // One, One: exact price, no change
        step(0, 1, 0); step(0, 1, 0); idle(2);
        // Half x3 then One: one unit of change on the default instance
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 1, 0); idle(3);
        // Half+One together, then cancel: three refund pulses on both
        step(1, 1, 0); step(0, 0, 1); idle(4);
        // Coins and cancel during RETURN are rejected / ignored
        step(1, 1, 0); step(0, 0, 1); step(0, 1, 0); step(0, 1, 1); idle(3);
        // One, Half, One
        step(0, 1, 0); step(1, 0, 0); step(0, 1, 0); idle(3);
        // Largest sum: credit 3 plus both coins = PRICE+2
        step(1, 1, 0); step(1, 1, 0); idle(3);
        // Cancel with nothing inserted, then cancel carrying a coin
        step(0, 0, 1); step(1, 0, 1); idle(2);

        // Reset after the first of three refund pulses
        piHalf = 1'b1; piOne = 1'b1; piCancel = 1'b1;
        q0.push_back(model_step(0, 1, 1, 1));
        q1.push_back(model_step(1, 1, 1, 1));
        @(posedge sys_clk);
        #1;
        compare(0, q0.pop_front());
        compare(1, q1.pop_front());
        piHalf = 1'b0; piOne = 1'b0; piCancel = 1'b0;
        sysRstN = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("midreset");
        repeat (2) @(posedge sys_clk);
        #1;
        check_idle_outputs("heldreset");
        @(negedge sys_clk);
        sysRstN = 1'b1;
        idle(3);
        step(0, 1, 0); step(0, 1, 0); idle(2);

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
